// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative HI/LO multiply/divide unit, one bit per cycle
//
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   start, op          launch MULT(00) / MULTU(01) / DIV(10) / DIVU(11); accepted only when idle
//   opa, opb           rs / rt operands, latched on the accepting edge
//   mthi, mtlo, mtdata direct writes of HI / LO while idle
//   busy, done         operation in progress / one-cycle completion pulse
//   div_by_zero        last completed divide had a zero divisor (sticky until next start)
//   hi, lo             architectural HI / LO registers

module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] mtdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   a_q;        // multiplicand magnitude (MUL) / dividend magnitude (DIV)
    logic [WIDTH-1:0]   b_q;        // divisor magnitude
    logic               sa_q;
    logic               sb_q;
    logic               is_div_q;
    logic [2*WIDTH-1:0] acc_q;      // product accumulator, or remainder:quotient shift register
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               done_q;
    logic               dbz_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    logic               op_signed;
    logic [WIDTH-1:0]   opa_mag;
    logic [WIDTH-1:0]   opb_mag;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] acc_mul_d;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     rem_diff;
    logic               q_bit;
    logic [WIDTH-1:0]   rem_new;
    logic [2*WIDTH-1:0] acc_div_d;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   a_raw;
    logic               last_iter;

    always_comb begin
        op_signed = ~op[0];
        opa_mag   = (op_signed && opa[WIDTH-1]) ? -opa : opa;
        opb_mag   = (op_signed && opb[WIDTH-1]) ? -opb : opb;

        // Shift-add: multiplier sits in the low half and is consumed LSB first;
        // the partial product enters from the top as the accumulator shifts right.
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
        acc_mul_d = {mul_sum, acc_q[WIDTH-1:1]};

        // Restoring divide: remainder is one bit wider while shifted so the
        // trial subtraction's MSB is a clean borrow flag.
        rem_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, b_q};
        q_bit     = ~rem_diff[WIDTH];
        rem_new   = q_bit ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        acc_div_d = {rem_new, acc_q[WIDTH-2:0], q_bit};

        prod_fix  = (sa_q ^ sb_q) ? -acc_q : acc_q;
        quot_fix  = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix   = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

        // Divide-by-zero returns the dividend exactly as it was presented.
        a_raw     = sa_q ? -a_q : a_q;
        last_iter = (cnt_q == CNT_W'(WIDTH-1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            is_div_q <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        // MUL: a_q = multiplicand, acc low = multiplier.
                        // DIV: b_q = divisor,      acc low = dividend.
                        a_q      <= opa_mag;
                        b_q      <= opb_mag;
                        sa_q     <= op_signed & opa[WIDTH-1];
                        sb_q     <= op_signed & opb[WIDTH-1];
                        is_div_q <= op[1];
                        acc_q    <= {{WIDTH{1'b0}}, (op[1] ? opa_mag : opb_mag)};
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        dbz_q    <= 1'b0;
                        state_q  <= op[1] ? S_DIV : S_MUL;
                    end else begin
                        if (mthi) hi_q <= mtdata;
                        if (mtlo) lo_q <= mtdata;
                    end
                end
                S_MUL: begin
                    acc_q <= acc_mul_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (last_iter) state_q <= S_FIX;
                end
                S_DIV: begin
                    if (b_q == '0) begin
                        hi_q    <= a_raw;
                        lo_q    <= '1;
                        dbz_q   <= 1'b1;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        acc_q <= acc_div_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (last_iter) state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (is_div_q) begin
                        lo_q <= quot_fix;
                        hi_q <= rem_fix;
                    end else begin
                        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fix[WIDTH-1:0];
                    end
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - self-checking bench for mult_div_unit

module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        mthi;
    logic        mtlo;
    logic [31:0] mtdata;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .opb(opb),
        .mthi(mthi), .mtlo(mtlo), .mtdata(mtdata),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic signed [63:0] ps;
        logic [63:0]        pu;
        e.dbz = 1'b0;
        e.hi  = '0;
        e.lo  = '0;
        case (o)
            2'b00: begin
                ps = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                {e.hi, e.lo} = ps;
            end
            2'b01: begin
                pu = {32'b0, a} * {32'b0, b};
                {e.hi, e.lo} = pu;
            end
            default: begin
                if (b == 32'd0) begin
                    e.hi = a; e.lo = 32'hFFFF_FFFF; e.dbz = 1'b1;
                end else if (o == 2'b10) begin
                    e.lo = $signed(a) / $signed(b);
                    e.hi = $signed(a) % $signed(b);
                end else begin
                    e.lo = a / b;
                    e.hi = a % b;
                end
            end
        endcase
        return e;
    endfunction

    // Launch one operation, scramble the inputs after acceptance, optionally
    // disturb it (re-start, MTHI, reset at a given edge), then wait for done.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input exp_t e, input int elat,
                          input bit mt_at_start, input int repulse_at, input int mthi_at,
                          input int rst_at);
        exp_t got;
        int   lat = -1;
        if (rst_at == 0) sb_q.push_back(e);
        op = o; opa = a; opb = b; start = 1'b1;
        if (mt_at_start) begin
            mthi = 1'b1; mtlo = 1'b1; mtdata = $urandom;
        end
        tick();                                 // E0
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        op = 2'($urandom_range(3)); opa = $urandom; opb = $urandom;
        chk({tag, ".busy_e0"}, busy, 1);
        chk({tag, ".done_e0"}, done, 0);
        chk({tag, ".dbz_e0"}, div_by_zero, 0);
        chk({tag, ".hi_e0"}, hi, m_hi);
        chk({tag, ".lo_e0"}, lo, m_lo);
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            start = (k == repulse_at);
            mthi  = (k == mthi_at);
            if (k == mthi_at) mtdata = 32'h0000_DEAD;
            rst   = (k == rst_at);
            tick();                             // E_k
            start = 1'b0; mthi = 1'b0; rst = 1'b0;
            if (done) begin
                lat = k;
            end else if (rst_at != 0 && k >= rst_at) begin
                if (k == rst_at) begin
                    m_hi = '0; m_lo = '0;
                end
                chk({tag, ".busy_after_rst"}, busy, 0);
                chk({tag, ".hi_after_rst"}, hi, m_hi);
                chk({tag, ".lo_after_rst"}, lo, m_lo);
            end else begin
                chk({tag, ".busy_run"}, busy, 1);
                chk({tag, ".hi_hold"}, hi, m_hi);
                chk({tag, ".lo_hold"}, lo, m_lo);
            end
        end
        if (rst_at != 0) begin
            chk({tag, ".no_done_after_rst"}, (lat < 0), 1);
        end else begin
            chk({tag, ".latency"}, lat, elat);
            chk({tag, ".sb_nonempty"}, (sb_q.size() > 0), 1);
            if (sb_q.size() > 0) begin
                got = sb_q.pop_front();
                chk({tag, ".hi"}, hi, got.hi);
                chk({tag, ".lo"}, lo, got.lo);
                chk({tag, ".dbz"}, div_by_zero, got.dbz);
                chk({tag, ".busy_done"}, busy, 0);
                m_hi = got.hi;
                m_lo = got.lo;
            end
        end
    endtask

    initial begin
        exp_t        e;
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;

        rst = 1'b1; start = 1'b0; op = 2'b00; opa = '0; opb = '0;
        mthi = 1'b0; mtlo = 1'b0; mtdata = '0;
        m_hi = '0; m_lo = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset.hi", hi, 0);
        chk("reset.lo", lo, 0);
        chk("reset.busy", busy, 0);
        chk("reset.done", done, 0);
        chk("reset.dbz", div_by_zero, 0);

        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               '{32'hFFFF_FFFE, 32'h0000_0001, 1'b0}, 33, 1'b0, 0, 0, 0);
        run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7,
               '{32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0}, 33, 1'b0, 0, 0, 0);
        run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2,
               '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0}, 33, 1'b0, 0, 0, 0);
        run_op("divu_100_7_mt", 2'b11, 32'd100, 32'd7,
               '{32'd2, 32'd14, 1'b0}, 33, 1'b1, 0, 0, 0);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF,
               '{32'h0, 32'h8000_0000, 1'b0}, 33, 1'b0, 0, 0, 0);
        run_op("divu_by0", 2'b11, 32'd5, 32'd0,
               '{32'd5, 32'hFFFF_FFFF, 1'b1}, 1, 1'b0, 0, 0, 0);
        run_op("div_by0_neg", 2'b10, 32'hFFFF_FFF0, 32'd0,
               '{32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1}, 1, 1'b0, 0, 0, 0);
        run_op("mult_disturb", 2'b00, 32'd6, 32'd7,
               '{32'd0, 32'd42, 1'b0}, 33, 1'b0, 5, 7, 0);
        run_op("mult_rst", 2'b00, 32'd6, 32'd7,
               '{32'd0, 32'd42, 1'b0}, 33, 1'b0, 0, 0, 10);

        mtlo = 1'b1; mtdata = 32'h0000_1234;
        tick();
        mtlo = 1'b0;
        chk("mtlo.lo", lo, 32'h0000_1234);
        chk("mtlo.hi", hi, 32'h0);
        mthi = 1'b1; mtlo = 1'b1; mtdata = 32'hCAFE_F00D;
        tick();
        mthi = 1'b0; mtlo = 1'b0;
        chk("mtboth.hi", hi, 32'hCAFE_F00D);
        chk("mtboth.lo", lo, 32'hCAFE_F00D);
        m_hi = 32'hCAFE_F00D;
        m_lo = 32'hCAFE_F00D;

        for (int i = 0; i < 8; i++) begin
            ro = 2'(i % 4);
            ra = $urandom;
            rb = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            if (ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) ra = 32'd1;
            e = model(ro, ra, rb);
            run_op("random", ro, ra, rb, e, (ro[1] && rb == 0) ? 1 : 33, 1'b0, 0, 0, 0);
        end

        tick();
        chk("final.done_low", done, 0);
        chk("final.busy_low", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
